srio_target_responder: RTL and testbench
========================================

Name: srio_target_responder

Overview:
- Target-side (mirror-end) logical-layer responder for the SRIO link between the primary and mirror srio_gen2 example tops.
- Consumes HELLO-format request packets from the core's target request AXI4-Stream (treq) and services NREAD / NWRITE / NWRITE_R against an internal 64-bit-wide memory.
- Returns HELLO-format responses on the target response stream (tresp).
- Pairs with the primary-side request generator as the other end of the same request/response protocol.

Parameters:
- MEM_DEPTH, 256: number of 64-bit memory words (power of 2).
- CNT_W, 16: width of the saturating statistics counters.

Ports:
- sys_clk  in  1  single clock (core log_clk domain)
- sys_rst  in  1  asynchronous active-high reset
- treq_tvalid  in  1  request beat valid
- treq_tready  out  1  request beat accepted
- treq_tdata  in  64  header beat, then payload
- treq_tkeep  in  8  byte enables (ignored; always full)
- treq_tlast  in  1  last beat of request packet
- treq_tuser  in  32  [31:16] src_id, [15:0] dest_id
- tresp_tvalid  out  1  response beat valid
- tresp_tready  in  1  downstream accepts beat
- tresp_tdata  out  64  response header, then data
- tresp_tkeep  out  8  always 8'hFF
- tresp_tlast  out  1  last response beat
- tresp_tuser  out  32  src/dest swapped from request
- nread_cnt  out  CNT_W  NREADs serviced
- nwrite_cnt  out  CNT_W  NWRITE + NWRITE_R serviced
- err_cnt  out  CNT_W  malformed or unsupported requests

Behaviour:
- Header fields: tid[63:56], ftype[55:52], ttype[51:48], prio[46:45], crf[44], size[43:36] (bytes-1), addr[33:0].
- Word index = addr[3+log2(MEM_DEPTH)-1:3]. Beat count N = size[7:3]+1. Index increments per beat and wraps modulo MEM_DEPTH.
- Response header fields:
  - tid copied from request; ftype=4'hD.
  - ttype=4'h8 (with data) or 4'h0 (no data).
  - prio = request prio+1, saturating at 3; crf copied.
  - status[35:32]: 0=DONE, 7=ERROR; all other bits 0.
- tresp_tuser = {req dest_id, req src_id}.
- FSM states: IDLE, WR_DATA, RD_RESP_HDR, RD_RESP_DATA, WR_RESP, DROP, ERR_RESP.
  - IDLE: treq_tready=1; on header handshake, latch fields.
    - ftype 2 / ttype 4 (NREAD) with tlast → RD_RESP_HDR.
    - ftype 5 / ttype 4 (NWRITE) or ttype 5 (NWRITE_R) without tlast → WR_DATA.
    - Anything else: if tlast → ERR_RESP; otherwise → DROP.
  - WR_DATA: tready=1; each accepted beat writes mem[idx].
    - tlast on beat N → NWRITE to IDLE; NWRITE_R to WR_RESP.
    - tlast before beat N → err_cnt++; NWRITE to IDLE, NWRITE_R to ERR_RESP.
    - Beat N without tlast → stop writing, go to DROP.
  - DROP: tready=1; discard until tlast, then err_cnt++ and → ERR_RESP (NWRITE → IDLE).
  - RD_RESP_HDR: drive header with ttype 8, status 0 → RD_RESP_DATA on handshake.
  - RD_RESP_DATA: emit N beats of mem[idx..]; tlast on beat N → IDLE, nread_cnt++.
  - WR_RESP / ERR_RESP: single header beat with tlast=1, status 0 or 7 respectively → IDLE.
  - treq_tready=0 in all response states (one transaction outstanding).
- Latency:
  - NREAD header accepted at cycle T → tresp_tvalid asserted by T+2.
  - Data beats may have at most one bubble before the first data beat; after that, 1 beat/cycle while tresp_tready=1.
- AXI rules:
  - Once tvalid is high, tdata/tlast/tuser are held stable and tvalid is not dropped until handshake.
  - Backpressure stalls without loss or duplication.
- Counters saturate at all-ones, never wrap; nwrite_cnt increments at the accepted tlast of a well-formed write.
- Reset:
  - All outputs 0 except tresp_tkeep=8'hFF and treq_tready=0 while sys_rst=1 (1 from the first cycle after release).
  - FSM → IDLE, counters cleared; memory contents not reset.
  - Reset mid-packet abandons the transaction; the remainder of an interrupted request is treated as a new header.

Test Plan:
- NWRITE_R addr 0x40, size 15, data 0x1111…, 0x2222… → mem[8],mem[9] written; one response with ftype D, ttype 0, status 0, tid echoed, tlast=1; nwrite_cnt=1.
- NREAD addr 0x40, size 15, tid 0x5A, prio 1 → header ttype 8, prio 2, then 0x1111…, 0x2222…, tlast on beat 2; nread_cnt=1; tuser swapped.
- NREAD at last word (idx MEM_DEPTH-1), size 15 → data from mem[MEM_DEPTH-1] then mem[0].
- Random tresp_tready toggling (50%) during a 32-beat NREAD → 32 data beats in order, no duplicates, stable while stalled.
- NWRITE_R declaring size 23 but tlast on beat 2 → err_cnt=1; ERROR response with status 7; nwrite_cnt unchanged.
- ftype 8 maintenance request with 3 beats → all beats consumed; ERROR response; err_cnt++. Assert sys_rst mid NREAD response → tresp_tvalid=0 immediately; next NREAD serviced normally.

Source files
------------

// File: rtl/srio_target_responder.sv
// Mirror-end SRIO logical-layer responder: services HELLO-format
// NREAD / NWRITE / NWRITE_R requests against a 64-bit word memory.
module srio_target_responder #(
    parameter int MEM_DEPTH = 256,
    parameter int CNT_W     = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             treq_tvalid,
    output logic             treq_tready,
    input  logic [63:0]      treq_tdata,
    input  logic [7:0]       treq_tkeep,
    input  logic             treq_tlast,
    input  logic [31:0]      treq_tuser,
    output logic             tresp_tvalid,
    input  logic             tresp_tready,
    output logic [63:0]      tresp_tdata,
    output logic [7:0]       tresp_tkeep,
    output logic             tresp_tlast,
    output logic [31:0]      tresp_tuser,
    output logic [CNT_W-1:0] nread_cnt,
    output logic [CNT_W-1:0] nwrite_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        RD_RESP_HDR,
        RD_RESP_DATA,
        WR_RESP,
        DROP,
        ERR_RESP
    } state_t;

    state_t state, state_nx;

    logic [63:0]   mem [MEM_DEPTH];
    logic [AW-1:0] idx;
    logic [4:0]    beat;
    logic [4:0]    last_beat;
    logic [7:0]    tid;
    logic [1:0]    rprio;
    logic          crf;
    logic [31:0]   user_q;
    logic          is_nw;

    logic req_hs;
    logic rsp_hs;
    logic end_beat;
    logic err_inc;
    logic nwr_inc;
    logic nrd_inc;

    logic [3:0] h_ftype;
    logic [3:0] h_ttype;
    logic [1:0] h_prio;
    logic       h_nread;
    logic       h_nwr;
    logic       unused_bits;

    assign h_ftype = treq_tdata[55:52];
    assign h_ttype = treq_tdata[51:48];
    assign h_prio  = treq_tdata[46:45];
    assign h_nread = (h_ftype == 4'h2) && (h_ttype == 4'h4);
    assign h_nwr   = (h_ftype == 4'h5) &&
                     ((h_ttype == 4'h4) || (h_ttype == 4'h5));

    assign req_hs   = treq_tvalid && treq_tready;
    assign rsp_hs   = tresp_tvalid && tresp_tready;
    assign end_beat = (beat == last_beat);

    assign tresp_tkeep = 8'hFF;

    assign unused_bits = ^{treq_tkeep, treq_tdata[47],
                           treq_tdata[35:34], treq_tdata[33:AW+3]};

    function automatic logic [63:0] rsp_hdr(
        input logic [3:0] tt,
        input logic [3:0] st
    );
        return {tid, 4'hD, tt, 1'b0, rprio, crf,
                8'h00, st, 32'h0};
    endfunction

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        err_inc  = 1'b0;
        nwr_inc  = 1'b0;
        nrd_inc  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_hs) begin
                    if (h_nread && treq_tlast) begin
                        state_nx = RD_RESP_HDR;
                    end else if (h_nwr && !treq_tlast) begin
                        state_nx = WR_DATA;
                    end else if (treq_tlast) begin
                        state_nx = ERR_RESP;
                        err_inc  = 1'b1;
                    end else begin
                        state_nx = DROP;
                    end
                end
            end
            WR_DATA: begin
                if (req_hs) begin
                    if (treq_tlast && end_beat) begin
                        nwr_inc  = 1'b1;
                        state_nx = is_nw ? IDLE : WR_RESP;
                    end else if (treq_tlast) begin
                        err_inc  = 1'b1;
                        state_nx = is_nw ? IDLE : ERR_RESP;
                    end else if (end_beat) begin
                        state_nx = DROP;
                    end
                end
            end
            DROP: begin
                if (req_hs && treq_tlast) begin
                    err_inc  = 1'b1;
                    state_nx = is_nw ? IDLE : ERR_RESP;
                end
            end
            RD_RESP_HDR: begin
                if (tresp_tready) state_nx = RD_RESP_DATA;
            end
            RD_RESP_DATA: begin
                if (tresp_tready && end_beat) begin
                    nrd_inc  = 1'b1;
                    state_nx = IDLE;
                end
            end
            WR_RESP, ERR_RESP: begin
                if (tresp_tready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        treq_tready  = 1'b0;
        tresp_tvalid = 1'b0;
        tresp_tdata  = 64'h0;
        tresp_tlast  = 1'b0;
        tresp_tuser  = 32'h0;
        unique case (state)
            IDLE, WR_DATA, DROP: treq_tready = !sys_rst;
            RD_RESP_HDR: begin
                tresp_tvalid = 1'b1;
                tresp_tdata  = rsp_hdr(4'h8, 4'h0);
            end
            RD_RESP_DATA: begin
                tresp_tvalid = 1'b1;
                tresp_tdata  = mem[idx];
                tresp_tlast  = end_beat;
            end
            WR_RESP: begin
                tresp_tvalid = 1'b1;
                tresp_tdata  = rsp_hdr(4'h0, 4'h0);
                tresp_tlast  = 1'b1;
            end
            ERR_RESP: begin
                tresp_tvalid = 1'b1;
                tresp_tdata  = rsp_hdr(4'h0, 4'h7);
                tresp_tlast  = 1'b1;
            end
            default: ;
        endcase
        if (tresp_tvalid) tresp_tuser = user_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            idx       <= '0;
            beat      <= '0;
            last_beat <= '0;
            tid       <= '0;
            rprio     <= '0;
            crf       <= 1'b0;
            user_q    <= '0;
            is_nw     <= 1'b0;
        end else if (state == IDLE && req_hs) begin
            idx       <= treq_tdata[AW+2:3];
            beat      <= '0;
            last_beat <= treq_tdata[43:39];
            tid       <= treq_tdata[63:56];
            rprio     <= (h_prio == 2'd3) ? 2'd3 : h_prio + 2'd1;
            crf       <= treq_tdata[44];
            user_q    <= {treq_tuser[15:0], treq_tuser[31:16]};
            is_nw     <= (h_ftype == 4'h5) && (h_ttype == 4'h4);
        end else if ((state == WR_DATA && req_hs) ||
                     (state == RD_RESP_DATA && rsp_hs)) begin
            idx  <= idx + AW'(1);
            beat <= beat + 5'd1;
        end
    end

    // Memory is deliberately left out of reset.
    always_ff @(posedge sys_clk) begin
        if (state == WR_DATA && req_hs) mem[idx] <= treq_tdata;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            nread_cnt  <= '0;
            nwrite_cnt <= '0;
            err_cnt    <= '0;
        end else begin
            if (nrd_inc && nread_cnt != '1)
                nread_cnt <= nread_cnt + CNT_W'(1);
            if (nwr_inc && nwrite_cnt != '1)
                nwrite_cnt <= nwrite_cnt + CNT_W'(1);
            if (err_inc && err_cnt != '1)
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_srio_target_responder.sv
// Directed bench for srio_target_responder: writes, reads, wrap,
// backpressure, malformed requests and reset during a response.
module tb_srio_target_responder;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        treq_tvalid = 1'b0;
    logic        treq_tready;
    logic [63:0] treq_tdata = '0;
    logic [7:0]  treq_tkeep = 8'hFF;
    logic        treq_tlast = 1'b0;
    logic [31:0] treq_tuser = '0;
    logic        tresp_tvalid;
    logic        tresp_tready = 1'b0;
    logic [63:0] tresp_tdata;
    logic [7:0]  tresp_tkeep;
    logic        tresp_tlast;
    logic [31:0] tresp_tuser;
    logic [15:0] nread_cnt;
    logic [15:0] nwrite_cnt;
    logic [15:0] err_cnt;

    int vec  = 0;
    int miss = 0;

    logic [31:0] req_user = 32'hABCD_1234;
    logic [63:0] pay   [32];
    logic [63:0] exp_d [32];

    localparam logic [63:0] D1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] D2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] DA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] DB = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [31:0] SWAP = 32'h1234_ABCD;

    always #5 sys_clk = ~sys_clk;

    srio_target_responder #(.MEM_DEPTH(256), .CNT_W(16)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .treq_tvalid(treq_tvalid),
        .treq_tready(treq_tready),
        .treq_tdata(treq_tdata),
        .treq_tkeep(treq_tkeep),
        .treq_tlast(treq_tlast),
        .treq_tuser(treq_tuser),
        .tresp_tvalid(tresp_tvalid),
        .tresp_tready(tresp_tready),
        .tresp_tdata(tresp_tdata),
        .tresp_tkeep(tresp_tkeep),
        .tresp_tlast(tresp_tlast),
        .tresp_tuser(tresp_tuser),
        .nread_cnt(nread_cnt),
        .nwrite_cnt(nwrite_cnt),
        .err_cnt(err_cnt)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mkreq(
        input logic [7:0] tid, input logic [3:0] ft,
        input logic [3:0] tt, input logic [1:0] prio,
        input logic crf, input logic [7:0] size,
        input logic [33:0] addr);
        return {tid, ft, tt, 1'b0, prio, crf, size, 2'b00, addr};
    endfunction

    task automatic put(input logic [63:0] d, input logic l);
        int n = 0;
        treq_tvalid = 1'b1;
        treq_tdata  = d;
        treq_tlast  = l;
        treq_tuser  = req_user;
        while (!treq_tready && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        check("req_accept", 64'(treq_tready), 64'd1);
        @(negedge sys_clk);
    endtask

    task automatic send(input logic [63:0] h, input int nb);
        put(h, nb == 0);
        for (int i = 0; i < nb; i++) put(pay[i], i == nb - 1);
        treq_tvalid = 1'b0;
        treq_tlast  = 1'b0;
    endtask

    task automatic get_beat(input bit rnd,
                            output logic [63:0] d,
                            output logic l,
                            output logic [31:0] u,
                            output int w);
        bit done = 0;
        bit seen = 0;
        logic [63:0] hd = '0;
        w = 0; d = '0; l = 1'b0; u = '0;
        while (!done) begin
            tresp_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (seen) begin
                check("valid_hold", 64'(tresp_tvalid), 64'd1);
                check("stall_hold", tresp_tdata, hd);
            end
            if (tresp_tvalid && tresp_tready) begin
                d = tresp_tdata; l = tresp_tlast; u = tresp_tuser;
                done = 1;
            end else begin
                if (tresp_tvalid) begin
                    seen = 1;
                    hd = tresp_tdata;
                end
                w++;
                if (w > 200) begin
                    check("rsp_timeout", 64'd0, 64'd1);
                    done = 1;
                end
            end
            @(negedge sys_clk);
        end
        tresp_tready = 1'b0;
    endtask

    task automatic resp1(input logic [63:0] hexp);
        logic [63:0] d; logic l; logic [31:0] u; int w;
        get_beat(0, d, l, u, w);
        check("rsp_hdr", d, hexp);
        check("rsp_last", 64'(l), 64'd1);
        check("rsp_user", 64'(u), 64'(SWAP));
    endtask

    task automatic read_resp(input logic [63:0] hexp,
                             input int nb, input bit rnd);
        logic [63:0] d; logic l; logic [31:0] u; int w;
        get_beat(rnd, d, l, u, w);
        check("rd_hdr", d, hexp);
        check("rd_hdr_last", 64'(l), 64'd0);
        check("rd_user", 64'(u), 64'(SWAP));
        if (!rnd) check("rd_hdr_lat", 64'(w <= 1), 64'd1);
        for (int i = 0; i < nb; i++) begin
            get_beat(rnd, d, l, u, w);
            check("rd_data", d, exp_d[i]);
            check("rd_last", 64'(l), 64'(i == nb - 1));
            if (!rnd && i == 0) check("rd_lat0", 64'(w <= 1), 64'd1);
            if (!rnd && i > 0)  check("rd_lat", 64'(w), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d; logic l; logic [31:0] u; int w;

        repeat (3) @(negedge sys_clk);
        check("rst_treq_tready", 64'(treq_tready), 64'd0);
        check("rst_tresp_tvalid", 64'(tresp_tvalid), 64'd0);
        check("rst_tkeep", 64'(tresp_tkeep), 64'hFF);
        check("rst_cnts", 64'({nread_cnt, nwrite_cnt, err_cnt}), 64'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("post_rst_tready", 64'(treq_tready), 64'd1);

        pay[0] = D1; pay[1] = D2;
        send(mkreq(8'h33, 4'h5, 4'h5, 2'd0, 1'b0, 8'd15, 34'h40), 2);
        resp1(64'h33D0_2000_0000_0000);
        check("nwrite_cnt1", 64'(nwrite_cnt), 64'd1);

        exp_d[0] = D1; exp_d[1] = D2;
        send(mkreq(8'h5A, 4'h2, 4'h4, 2'd1, 1'b0, 8'd15, 34'h40), 0);
        read_resp(64'h5AD8_4000_0000_0000, 2, 0);
        check("nread_cnt1", 64'(nread_cnt), 64'd1);

        pay[0] = DA; pay[1] = DB;
        send(mkreq(8'h44, 4'h5, 4'h4, 2'd0, 1'b0, 8'd15, 34'h7F8), 2);
        repeat (2) @(negedge sys_clk);
        check("nwrite_no_rsp", 64'(tresp_tvalid), 64'd0);
        check("nwrite_cnt2", 64'(nwrite_cnt), 64'd2);
        exp_d[0] = DA; exp_d[1] = DB;
        send(mkreq(8'h11, 4'h2, 4'h4, 2'd3, 1'b1, 8'd15, 34'h7F8), 0);
        read_resp(64'h11D8_7000_0000_0000, 2, 0);
        exp_d[0] = DB;
        send(mkreq(8'h12, 4'h2, 4'h4, 2'd0, 1'b0, 8'd7, 34'h0), 0);
        read_resp(64'h12D8_2000_0000_0000, 1, 0);

        for (int i = 0; i < 32; i++) begin
            pay[i]   = 64'hC0DE_0000_0000_0000 | 64'(i);
            exp_d[i] = pay[i];
        end
        send(mkreq(8'h55, 4'h5, 4'h4, 2'd0, 1'b0, 8'd255, 34'h100), 32);
        send(mkreq(8'h66, 4'h2, 4'h4, 2'd2, 1'b0, 8'd255, 34'h100), 0);
        read_resp(64'h66D8_6000_0000_0000, 32, 1);
        check("nread_cnt4", 64'(nread_cnt), 64'd4);
        check("nwrite_cnt3", 64'(nwrite_cnt), 64'd3);

        pay[0] = D1; pay[1] = D2;
        send(mkreq(8'h77, 4'h5, 4'h5, 2'd0, 1'b0, 8'd23, 34'h40), 2);
        resp1(64'h77D0_2007_0000_0000);
        check("err_cnt1", 64'(err_cnt), 64'd1);
        check("nwrite_cnt_keep", 64'(nwrite_cnt), 64'd3);

        send(mkreq(8'h88, 4'h8, 4'h0, 2'd0, 1'b0, 8'd0, 34'h0), 2);
        resp1(64'h88D0_2007_0000_0000);
        check("err_cnt2", 64'(err_cnt), 64'd2);

        send(mkreq(8'h99, 4'h2, 4'h4, 2'd0, 1'b0, 8'd255, 34'h100), 0);
        get_beat(0, d, l, u, w);
        check("mid_hdr", d, 64'h99D8_2000_0000_0000);
        for (int i = 0; i < 3; i++) begin
            get_beat(0, d, l, u, w);
            check("mid_data", d, exp_d[i]);
        end
        sys_rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(tresp_tvalid), 64'd0);
        check("mid_rst_tready", 64'(treq_tready), 64'd0);
        check("mid_rst_tdata", tresp_tdata, 64'd0);
        check("mid_rst_cnts", 64'({nread_cnt, err_cnt}), 64'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("mid_rel_tready", 64'(treq_tready), 64'd1);
        exp_d[0] = D1; exp_d[1] = D2;
        send(mkreq(8'h5A, 4'h2, 4'h4, 2'd1, 1'b0, 8'd15, 34'h40), 0);
        read_resp(64'h5AD8_4000_0000_0000, 2, 0);
        check("nread_after_rst", 64'(nread_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
